// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the SPARC fetch stage: FSM states, trap codes,
// the RAM opcode used for instruction reads, and the redirect request bundle.
package sparc_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ = 2'd0,
        WAIT_MFC  = 2'd1,
        ISSUE     = 2'd2,
        TRAP      = 2'd3
    } fetch_state_e;

    typedef enum logic [2:0] {
        TT_NONE     = 3'b000,
        TT_IACCESS  = 3'b001,
        TT_MISALIGN = 3'b010
    } trap_type_e;

    localparam logic [5:0]  RAM_OP_LDW = 6'b000000;
    localparam logic [31:0] WORD_STEP  = 32'd4;

    // Control-unit redirect request, meaningful only alongside exec_done.
    typedef struct packed {
        logic        redirect;
        logic        annul;
        logic [31:0] target;
    } redirect_req_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the RAM read port and control-unit handshake around the fetch stage.
// master = fetch unit side, slave = RAM / control unit side.
interface instruction_fetch_unit_if;

    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [5:0]  RAM_OpCode;
    logic [31:0] mem_data;
    logic        MFC;

    logic [31:0] IR_Out;
    logic        ir_valid;
    logic        exec_done;
    logic        redirect;
    logic        annul;
    logic [31:0] redirect_target;

    logic        trap_ack;
    logic [31:0] trap_vector;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        fetch_err;
    logic [2:0]  tt;

    modport master (
        output mem_addr, mem_rd, RAM_OpCode, IR_Out, ir_valid, PC, NPC, fetch_err, tt,
        input  mem_data, MFC, exec_done, redirect, annul, redirect_target, trap_ack, trap_vector
    );

    modport slave (
        input  mem_addr, mem_rd, RAM_OpCode, IR_Out, ir_valid, PC, NPC, fetch_err, tt,
        output mem_data, MFC, exec_done, redirect, annul, redirect_target, trap_ack, trap_vector
    );

endinterface

// File: rtl/instruction_fetch_unit_pc_seq.sv
// PC/nPC register pair: delayed-branch / annul next-PC selection, trap vector
// load and reset load.
module fetch_pc_sequencer
    import sparc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          Clk,
    input  logic          RESET,
    input  logic          advance,
    input  redirect_req_t req,
    input  logic          trap_load,
    input  logic [31:0]   trap_vector,
    output logic [31:0]   pc,
    output logic [31:0]   npc
);

    logic [31:0] pc_nxt, npc_nxt;

    always_comb begin
        pc_nxt  = pc;
        npc_nxt = npc;
        if (trap_load) begin
            pc_nxt  = trap_vector;
            npc_nxt = trap_vector + WORD_STEP;
        end else if (advance) begin
            unique case ({req.redirect, req.annul})
                2'b00: begin
                    pc_nxt  = npc;
                    npc_nxt = npc + WORD_STEP;
                end
                2'b10: begin
                    pc_nxt  = npc;
                    npc_nxt = req.target;
                end
                2'b11: begin
                    pc_nxt  = req.target;
                    npc_nxt = req.target + WORD_STEP;
                end
                default: begin
                    // untaken with annul: skip the delay slot
                    pc_nxt  = npc + WORD_STEP;
                    npc_nxt = npc + (WORD_STEP << 1);
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!RESET) begin
            pc  <= RESET_PC;
            npc <= RESET_PC + WORD_STEP;
        end else begin
            pc  <= pc_nxt;
            npc <= npc_nxt;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// SPARC fetch stage: FSM, MFC timeout counter and IR latch around fetch_pc_sequencer.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned PCs instead of issuing the read.
module instruction_fetch_unit
    import sparc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MFC_TIMEOUT = 16
) (
    input  logic                      Clk,
    input  logic                      RESET,
    instruction_fetch_unit_if.master  bus
);

    localparam logic [7:0] TMO_LAST = 8'(MFC_TIMEOUT - 1);

    fetch_state_e  state, state_nxt;
    logic [7:0]    tmo_cnt, tmo_cnt_nxt;
    logic [31:0]   ir_q, ir_nxt;
    trap_type_e    tt_q, tt_nxt;
    logic          advance, trap_load, misaligned;
    logic [31:0]   pc, npc;
    redirect_req_t req;

    assign req = '{redirect: bus.redirect, annul: bus.annul, target: bus.redirect_target};

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(pc);
`else
    assign misaligned = 1'b0;
`endif

    fetch_pc_sequencer #(.RESET_PC(RESET_PC)) u_pc_seq (
        .Clk         (Clk),
        .RESET       (RESET),
        .advance     (advance),
        .req         (req),
        .trap_load   (trap_load),
        .trap_vector (bus.trap_vector),
        .pc          (pc),
        .npc         (npc)
    );

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        ir_nxt      = ir_q;
        tt_nxt      = tt_q;
        advance     = 1'b0;
        trap_load   = 1'b0;
        unique case (state)
            FETCH_REQ: begin
                tmo_cnt_nxt = '0;
                if (misaligned) begin
                    state_nxt = TRAP;
                    tt_nxt    = TT_MISALIGN;
                end else begin
                    state_nxt = WAIT_MFC;
                end
            end
            WAIT_MFC: begin
                // a completing MFC beats the timeout on the last count
                if (bus.MFC) begin
                    ir_nxt    = bus.mem_data;
                    state_nxt = ISSUE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = TRAP;
                    tt_nxt    = TT_IACCESS;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            ISSUE: begin
                if (bus.exec_done) begin
                    advance   = 1'b1;
                    state_nxt = FETCH_REQ;
                end
            end
            TRAP: begin
                if (bus.trap_ack) begin
                    trap_load = 1'b1;
                    tt_nxt    = TT_NONE;
                    state_nxt = FETCH_REQ;
                end
            end
            default: state_nxt = FETCH_REQ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RESET) begin
            state   <= FETCH_REQ;
            tmo_cnt <= '0;
            ir_q    <= '0;
            tt_q    <= TT_NONE;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            ir_q    <= ir_nxt;
            tt_q    <= tt_nxt;
        end
    end

    // Read strobe is held off while reset is asserted even though state is FETCH_REQ.
    assign bus.mem_rd     = (state == FETCH_REQ) && RESET && !misaligned;
    assign bus.mem_addr   = pc;
    assign bus.RAM_OpCode = RAM_OP_LDW;
    assign bus.IR_Out     = ir_q;
    assign bus.ir_valid   = (state == ISSUE);
    assign bus.fetch_err  = (state == TRAP);
    assign bus.tt         = tt_q;
    assign bus.PC         = pc;
    assign bus.NPC        = npc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + randomized bench for instruction_fetch_unit against a PC/nPC
// reference model; inputs driven just after posedge, outputs sampled at negedge.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 16;

    logic Clk   = 1'b0;
    logic RESET = 1'b0;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(RST_PC), .MFC_TIMEOUT(TMO)) dut (
        .Clk   (Clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [31:0] m_pc, m_npc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic smp();
        @(negedge Clk);
    endtask

    // SPARC semantics: the delay slot runs unless annulled; a taken CTI lands after it.
    task automatic model_exec(input bit r, input bit a, input logic [31:0] tgt);
        if (r && a) begin
            m_pc  = tgt;
            m_npc = tgt + 32'd4;
        end else if (a) begin
            m_pc  = m_npc + 32'd4;
            m_npc = m_npc + 32'd8;
        end else begin
            m_pc  = m_npc;
            m_npc = r ? tgt : m_npc + 32'd4;
        end
    endtask

    task automatic chk_fetch_req(input string tag);
        chk({tag, ".mem_rd"},   {31'b0, bus.mem_rd}, 32'd1);
        chk({tag, ".mem_addr"}, bus.mem_addr, m_pc);
        chk({tag, ".opcode"},   {26'b0, bus.RAM_OpCode}, 32'd0);
        chk({tag, ".ir_valid"}, {31'b0, bus.ir_valid}, 32'd0);
        chk({tag, ".pc"},       bus.PC, m_pc);
        chk({tag, ".npc"},      bus.NPC, m_npc);
        chk({tag, ".fetch_err"},{31'b0, bus.fetch_err}, 32'd0);
    endtask

    // Starts at the negedge of a FETCH_REQ cycle; ends at the negedge of the first ISSUE cycle.
    task automatic fetch(input int delay, input logic [31:0] data);
        for (int i = 0; i < delay; i++) begin
            cyc(); bus.MFC = 1'b0; bus.mem_data = $urandom; smp();
            chk("wait.mem_rd",    {31'b0, bus.mem_rd}, 32'd0);
            chk("wait.ir_valid",  {31'b0, bus.ir_valid}, 32'd0);
            chk("wait.fetch_err", {31'b0, bus.fetch_err}, 32'd0);
        end
        cyc(); bus.MFC = 1'b1; bus.mem_data = data; smp();
        chk("mfc.fetch_err", {31'b0, bus.fetch_err}, 32'd0);
        cyc(); bus.MFC = 1'b0; bus.mem_data = $urandom; smp();
        chk("issue.ir_valid", {31'b0, bus.ir_valid}, 32'd1);
        chk("issue.ir_out",   bus.IR_Out, data);
    endtask

    // Holds ISSUE for `hold` cycles, then exec_done; ends at the negedge of the next FETCH_REQ.
    task automatic execute(input int hold, input bit r, input bit a, input logic [31:0] tgt);
        for (int i = 0; i < hold; i++) begin
            cyc(); bus.exec_done = 1'b0; bus.redirect = 1'($urandom); bus.annul = 1'($urandom); smp();
            chk("hold.ir_valid", {31'b0, bus.ir_valid}, 32'd1);
            chk("hold.pc",       bus.PC, m_pc);
        end
        cyc(); bus.exec_done = 1'b1; bus.redirect = r; bus.annul = a; bus.redirect_target = tgt; smp();
        model_exec(r, a, tgt);
        cyc();
        bus.exec_done = 1'b0; bus.redirect = 1'b0; bus.annul = 1'b0;
        bus.MFC = 1'($urandom); bus.mem_data = 32'hDEAD_BEEF;
        smp();
        chk_fetch_req("exec");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_data = '0; bus.MFC = 1'b0; bus.exec_done = 1'b0; bus.redirect = 1'b0;
        bus.annul = 1'b0; bus.redirect_target = '0; bus.trap_ack = 1'b0; bus.trap_vector = '0;
        m_pc  = RST_PC;
        m_npc = RST_PC + 32'd4;

        // reset state
        cyc(); cyc(); smp();
        chk("rst.mem_rd",    {31'b0, bus.mem_rd}, 32'd0);
        chk("rst.ir_out",    bus.IR_Out, 32'd0);
        chk("rst.ir_valid",  {31'b0, bus.ir_valid}, 32'd0);
        chk("rst.pc",        bus.PC, 32'h0);
        chk("rst.npc",       bus.NPC, 32'h4);
        chk("rst.fetch_err", {31'b0, bus.fetch_err}, 32'd0);
        chk("rst.tt",        {29'b0, bus.tt}, 32'd0);
        cyc(); RESET = 1'b1; smp();
        chk_fetch_req("first");

        // minimum latency fetch, then sequential
        fetch(0, 32'h8200_6005);
        execute(0, 1'b0, 1'b0, 32'h0);
        chk("seq.pc", bus.PC, 32'h4);
        chk("seq.npc", bus.NPC, 32'h8);
        chk("seq.addr", bus.mem_addr, 32'h4);
        fetch(2, 32'h1111_0001); execute(1, 1'b0, 1'b0, 32'h0);
        fetch(0, 32'h1111_0002); execute(0, 1'b0, 1'b0, 32'h0);
        fetch(3, 32'h1111_0003); execute(2, 1'b0, 1'b0, 32'h0);
        chk("at10.pc", bus.PC, 32'h10);
        chk("at10.npc", bus.NPC, 32'h14);

        // delayed branch
        fetch(1, 32'h2222_0001); execute(0, 1'b1, 1'b0, 32'h40);
        chk("br.pc", bus.PC, 32'h14);
        chk("br.npc", bus.NPC, 32'h40);
        fetch(0, 32'h2222_0002); execute(0, 1'b0, 1'b0, 32'h0);
        chk("br2.pc", bus.PC, 32'h40);
        chk("br2.npc", bus.NPC, 32'h44);

        // annul combinations from 0x10/0x14
        fetch(0, 32'h3333_0001); execute(0, 1'b1, 1'b1, 32'h10);
        chk("ann0.pc", bus.PC, 32'h10);
        fetch(0, 32'h3333_0002); execute(0, 1'b1, 1'b1, 32'h80);
        chk("annt.pc", bus.PC, 32'h80);
        chk("annt.npc", bus.NPC, 32'h84);
        fetch(0, 32'h3333_0003); execute(0, 1'b1, 1'b1, 32'h10);
        fetch(0, 32'h3333_0004); execute(0, 1'b0, 1'b1, 32'h0);
        chk("annu.pc", bus.PC, 32'h18);
        chk("annu.npc", bus.NPC, 32'h1C);

        // 32-bit wrap
        fetch(0, 32'h4444_0001); execute(0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap.pc", bus.PC, 32'hFFFF_FFFC);
        chk("wrap.npc", bus.NPC, 32'h0);
        fetch(0, 32'h4444_0002); execute(0, 1'b0, 1'b0, 32'h0);
        chk("wrap2.pc", bus.PC, 32'h0);
        chk("wrap2.npc", bus.NPC, 32'h4);

        // MFC arriving on the last permitted WAIT cycle wins over timeout
        fetch(TMO - 1, 32'h5555_0001); execute(0, 1'b0, 1'b0, 32'h0);

        // timeout trap, exec_done ignored in TRAP, trap_ack recovery
        for (int i = 0; i < TMO; i++) begin
            cyc(); bus.MFC = 1'b0; smp();
            chk("tmo.wait_err", {31'b0, bus.fetch_err}, 32'd0);
        end
        cyc(); bus.exec_done = 1'b1; bus.redirect = 1'b1; bus.annul = 1'b1;
        bus.redirect_target = 32'h999; smp();
        chk("tmo.fetch_err", {31'b0, bus.fetch_err}, 32'd1);
        chk("tmo.tt",        {29'b0, bus.tt}, 32'd1);
        chk("tmo.mem_rd",    {31'b0, bus.mem_rd}, 32'd0);
        chk("tmo.ir_valid",  {31'b0, bus.ir_valid}, 32'd0);
        cyc(); smp();
        chk("tmo.hold_err", {31'b0, bus.fetch_err}, 32'd1);
        chk("tmo.hold_pc",  bus.PC, m_pc);
        cyc(); bus.exec_done = 1'b0; bus.redirect = 1'b0; bus.annul = 1'b0;
        bus.trap_ack = 1'b1; bus.trap_vector = 32'h200; smp();
        cyc(); bus.trap_ack = 1'b0; smp();
        m_pc  = 32'h200;
        m_npc = 32'h204;
        chk_fetch_req("tack");
        chk("tack.tt", {29'b0, bus.tt}, 32'd0);
        chk("tack.pc", bus.PC, 32'h200);
        fetch(0, 32'h6666_0001); execute(0, 1'b0, 1'b0, 32'h0);

        // reset mid-WAIT with a coincident MFC
        fetch(1, 32'h7777_0001); execute(0, 1'b0, 1'b0, 32'h0);
        cyc(); bus.MFC = 1'b0; smp();
        cyc(); RESET = 1'b0; bus.MFC = 1'b1; bus.mem_data = 32'h1234_5678; smp();
        cyc(); RESET = 1'b1; bus.MFC = 1'b0; smp();
        m_pc  = RST_PC;
        m_npc = RST_PC + 32'd4;
        chk("rstw.ir_out",   bus.IR_Out, 32'd0);
        chk("rstw.ir_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk_fetch_req("rstw");

        // randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            fetch(int'($urandom_range(0, TMO - 1)), $urandom);
            execute(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC);
        end

`ifdef FETCH_ALIGN_CHECK_EN
        fetch(0, 32'h8888_0001);
        cyc(); bus.exec_done = 1'b1; bus.redirect = 1'b1; bus.annul = 1'b1;
        bus.redirect_target = 32'h42; smp();
        cyc(); bus.exec_done = 1'b0; bus.redirect = 1'b0; bus.annul = 1'b0; smp();
        chk("algn.mem_rd", {31'b0, bus.mem_rd}, 32'd0);
        chk("algn.pc",     bus.PC, 32'h42);
        cyc(); smp();
        chk("algn.fetch_err", {31'b0, bus.fetch_err}, 32'd1);
        chk("algn.tt",        {29'b0, bus.tt}, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the SPARC control unit.
- Owns the PC/nPC pair and issues word reads to RAM.
- Waits for MFC, latches the returned word into IR_Out, and presents it to the control unit with a valid/done handshake.
- Applies SPARC delayed-branch and annul sequencing from control-unit redirect inputs, and raises an instruction-access trap on memory timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (nPC = RESET_PC+4)
MFC_TIMEOUT, 16, cycles to wait in WAIT_MFC before trapping (1..255)

Ports:
Clk  in  1  system clock, all state updates on rising edge
RESET  in  1  synchronous reset, active-low (RESET==0 at posedge resets)
mem_addr  out  32  read address to RAM (equals PC)
mem_rd  out  1  RAM read strobe, one-cycle pulse
RAM_OpCode  out  6  RAM access type, fixed 6'b000000 (load word) during fetch
mem_data  in  32  RAM read data, valid when MFC=1
MFC  in  1  memory function complete
IR_Out  out  32  latched instruction
ir_valid  out  1  IR_Out holds an instruction awaiting execution
exec_done  in  1  control unit finished current instruction
redirect  in  1  branch/call/jmpl taken, sampled with exec_done
annul  in  1  annul delay slot, sampled with exec_done
redirect_target  in  32  target address, sampled with exec_done
trap_ack  in  1  trap handler accepts pending trap
trap_vector  in  32  new PC on trap_ack (TBR value)
PC  out  32  current PC
NPC  out  32  current nPC
fetch_err  out  1  trap pending
tt  out  3  trap type: 3'b000 none, 3'b001 access timeout, 3'b010 misaligned

Behaviour:
- Reset (RESET==0 at posedge):
  - State=FETCH_REQ; PC=RESET_PC; NPC=RESET_PC+4.
  - IR_Out=0; ir_valid=0; mem_rd=0; fetch_err=0; tt=0; timeout counter=0.
  - Reset overrides every other input, mid-fetch included; an outstanding MFC is discarded.
- FETCH_REQ: mem_rd=1, mem_addr=PC for exactly one cycle; next state WAIT_MFC; counter cleared. MFC seen in this cycle is ignored.
- WAIT_MFC: mem_rd=0.
  - MFC=1: IR_Out<=mem_data, go to ISSUE.
  - Otherwise counter+1. When counter reaches MFC_TIMEOUT-1 with MFC=0: go to TRAP, tt=3'b001.
  - MFC wins over timeout in the same cycle.
- ISSUE: ir_valid=1; IR_Out stable. Hold until exec_done=1, then ir_valid<=0, go to FETCH_REQ and update PC/NPC:
  - redirect=0, annul=0: PC<=NPC, NPC<=NPC+4
  - redirect=1, annul=0: PC<=NPC, NPC<=redirect_target
  - redirect=1, annul=1: PC<=redirect_target, NPC<=redirect_target+4
  - redirect=0, annul=1: PC<=NPC+4, NPC<=NPC+8
- Address arithmetic: 32-bit modulo 2^32, wrap silently.
- TRAP: fetch_err=1, mem_rd=0, ir_valid=0. On trap_ack: PC<=trap_vector, NPC<=trap_vector+4, fetch_err<=0, tt<=0, go to FETCH_REQ. exec_done is ignored outside ISSUE.
- Minimum latency: MFC in the first WAIT_MFC cycle puts ir_valid high 2 cycles after entering FETCH_REQ.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: in FETCH_REQ, if PC[1:0]!=0, mem_rd stays 0, go to TRAP with tt=3'b010 the next cycle.
- Undefined: no check; mem_addr is driven with PC as-is, and tt never takes 3'b010.

Decomposition:
- Package sparc_fetch_pkg holds:
  - State encoding: FETCH_REQ, WAIT_MFC, ISSUE, TRAP.
  - tt codes: TT_NONE, TT_IACCESS, TT_MISALIGN.
  - RAM_OP_LDW=6'b000000 and the WORD_STEP=4 constant.
- One sub-module, fetch_pc_sequencer: holds the PC/NPC registers and the four-way next-PC selection plus trap/reset load. The top level holds the FSM, timeout counter and IR latch.

Test Plan:
- Reset with RESET_PC=0, MFC returned 1 cycle after mem_rd, mem_data=32'h8200_6005 -> IR_Out=32'h8200_6005, ir_valid high 2 cycles after FETCH_REQ; exec_done -> PC=4, NPC=8, mem_addr=4.
- At PC=0x10, NPC=0x14: exec_done with redirect=1, annul=0, target=0x40 -> PC=0x14, NPC=0x40; then plain exec_done -> PC=0x40, NPC=0x44.
- annul=1 combinations from PC=0x10, NPC=0x14: redirect=1, target=0x80 -> PC=0x80, NPC=0x84; redirect=0 -> PC=0x18, NPC=0x1C.
- MFC held low with MFC_TIMEOUT=16 -> fetch_err=1 and tt=3'b001 after 16 WAIT_MFC cycles; trap_ack with trap_vector=0x200 -> PC=0x200, NPC=0x204, new fetch at 0x200.
- RESET driven low during WAIT_MFC, MFC pulsed in the same cycle -> IR_Out=0, ir_valid=0, PC=RESET_PC; the next fetch addresses RESET_PC.
- With FETCH_ALIGN_CHECK_EN: redirect to 0x42 then fetch -> no mem_rd pulse, tt=3'b010, fetch_err=1.
